// File: rtl/jesd204_ramp_checker_pkg.sv
// Shared definitions for the JESD204 ramp checker: FSM encoding, the K28.5
// comma value and ramp helpers used by the per-octet compare chain.
package jesd204_ramp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_K    = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_CHECK     = 2'd3
  } state_e;

  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] RAMP_MAX = 8'hFF;

  // The ramp wraps from its maximum back to 0x00.
  function automatic logic [7:0] ramp_next(input logic [7:0] v);
    return (v == RAMP_MAX) ? 8'h00 : v + 8'd1;
  endfunction

  function automatic logic is_clean_k(input logic [7:0] c, input logic k,
                                      input logic nit, input logic de);
    return k && !nit && !de && (c == K28_5);
  endfunction

endpackage

// File: rtl/jesd204_ramp_checker_sat_cnt.sv
// Saturating accumulator of per-beat errored octets; clear has priority over
// any errors arriving in the same beat.
module jesd204_ramp_checker_sat_cnt #(
  parameter int DW = 4,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear_i,
  input  logic [DW-1:0] err_i,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DW + 1);

  logic [PW-1:0] pop;
  logic [CW:0]   sum;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < DW; i++) begin
      pop = pop + PW'(err_i[i]);
    end
    sum = {1'b0, cnt_q} + (CW + 1)'(pop);
    if (clear_i) begin
      cnt_d = '0;
    end else if (sum[CW]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/jesd204_ramp_checker.sv
// Receive-side checker for a K28.5 run followed by an incrementing octet ramp.
// Define JESD204_RAMP_CHECKER_ERR_CAPTURE_EN to latch the first errored octet.
module jesd204_ramp_checker
  import jesd204_ramp_checker_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int ERR_CNT_WIDTH   = 32,
  parameter int LOCK_THRESHOLD  = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [8*DATA_PATH_WIDTH-1:0] char,
  input  logic [DATA_PATH_WIDTH-1:0]   charisk,
  input  logic [DATA_PATH_WIDTH-1:0]   notintable,
  input  logic [DATA_PATH_WIDTH-1:0]   disperr,
  output logic                         locked,
  output logic [1:0]                   state,
  output logic [DATA_PATH_WIDTH-1:0]   error,
  output logic [ERR_CNT_WIDTH-1:0]     error_count,
  output logic [7:0]                   first_err_expected,
  output logic [7:0]                   first_err_received
);

  localparam int DPW = DATA_PATH_WIDTH;

  state_e              state_q, state_d;
  logic [7:0]          exp_q, exp_d;
  logic [7:0]          good_q, good_d;
  logic                locked_q, locked_d;
  logic [DPW-1:0]      error_q, err_d;
  logic [7:0]          exp_chain [DPW+1];
  logic [DPW-1:0][7:0] oct_exp;
  logic [DPW-1:0]      oct_err, oct_clean_k;
  logic                has_data, check_beat, beat_bad;

  // Expected value ripples through the beat: K resets it, data advances it.
  assign exp_chain[0] = exp_q;
  for (genvar gi = 0; gi < DPW; gi++) begin : g_oct
    logic [7:0] oct;
    assign oct             = char[8*gi +: 8];
    assign oct_clean_k[gi] = is_clean_k(oct, charisk[gi], notintable[gi], disperr[gi]);
    assign oct_exp[gi]     = charisk[gi] ? K28_5 : exp_chain[gi];
    assign oct_err[gi]     = notintable[gi] | disperr[gi] | (oct != oct_exp[gi]);
    assign exp_chain[gi+1] = charisk[gi] ? 8'h00 : ramp_next(exp_chain[gi]);
  end

  // The WAIT_DATA beat that carries the first data octet is checked like CHECK.
  assign has_data   = ~&charisk;
  assign check_beat = enable && ((state_q == ST_CHECK) ||
                                 ((state_q == ST_WAIT_DATA) && has_data));
  assign err_d      = check_beat ? oct_err : '0;
  assign beat_bad   = |err_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_K;
        ST_WAIT_K:    if (|oct_clean_k) state_d = ST_WAIT_DATA;
        ST_WAIT_DATA: if (has_data) state_d = beat_bad ? ST_WAIT_K : ST_CHECK;
        ST_CHECK:     if (beat_bad) state_d = ST_WAIT_K;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    exp_d    = 8'h00;
    good_d   = good_q;
    locked_d = locked_q;
    if (state_d != ST_CHECK) begin
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      exp_d = exp_chain[DPW];
      if (has_data && (good_q < 8'(LOCK_THRESHOLD))) begin
        good_d = good_q + 8'd1;
      end
      locked_d = locked_q | (good_d == 8'(LOCK_THRESHOLD));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q    <= 8'h00;
      good_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= '0;
    end else begin
      exp_q    <= exp_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      error_q  <= err_d;
    end
  end

  jesd204_ramp_checker_sat_cnt #(
    .DW (DPW),
    .CW (ERR_CNT_WIDTH)
  ) u_sat_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (clear),
    .err_i   (err_d),
    .count_o (error_count)
  );

`ifdef JESD204_RAMP_CHECKER_ERR_CAPTURE_EN
  logic       cap_valid_q, cap_valid_d;
  logic [7:0] cap_exp_q, cap_exp_d, cap_rcv_q, cap_rcv_d;

  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_exp_d   = cap_exp_q;
    cap_rcv_d   = cap_rcv_q;
    if (clear) begin
      cap_valid_d = 1'b0;
      cap_exp_d   = 8'h00;
      cap_rcv_d   = 8'h00;
    end else if (!cap_valid_q && beat_bad) begin
      cap_valid_d = 1'b1;
      // Walk downward so the lowest-index errored octet is the one kept.
      for (int i = DPW - 1; i >= 0; i--) begin
        if (err_d[i]) begin
          cap_exp_d = oct_exp[i];
          cap_rcv_d = char[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_valid_q <= 1'b0;
      cap_exp_q   <= 8'h00;
      cap_rcv_q   <= 8'h00;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_exp_q   <= cap_exp_d;
      cap_rcv_q   <= cap_rcv_d;
    end
  end

  assign first_err_expected = cap_exp_q;
  assign first_err_received = cap_rcv_q;
`else
  assign first_err_expected = 8'h00;
  assign first_err_received = 8'h00;
`endif

  assign state  = state_q;
  assign locked = locked_q;
  assign error  = error_q;

endmodule
